// File: rtl/col_pkg.sv
// Shared types for the colour-quantiser pipeline: channel-select codes,
// the configuration word and the config FSM states.
package col_pkg;

    localparam logic [1:0] SEL_R   = 2'b00;
    localparam logic [1:0] SEL_G   = 2'b01;
    localparam logic [1:0] SEL_B   = 2'b10;
    localparam logic [1:0] SEL_ALL = 2'b11;

    typedef struct packed {
        logic [2:0] shift;
        logic [1:0] sels;
    } cfg_t;

    localparam cfg_t CFG_PASS = '{shift: 3'd0, sels: SEL_ALL};

    typedef enum logic [0:0] {
        ST_ACTIVE  = 1'b0,
        ST_PENDING = 1'b1
    } cfg_state_t;

endpackage

// File: rtl/col_quant_chan.sv
// Combinational single-channel quantiser: zeroes the low 'shift' bits.
// With COLQ_ROUND_EN defined it rounds to nearest first, saturating on overflow.
module col_quant_chan #(
    parameter int CH_W = 6
) (
    input  logic [CH_W-1:0] ch_i,
    input  logic [2:0]      shift_i,
    input  logic            en_i,
    output logic [CH_W-1:0] q_o
);

    logic [CH_W-1:0] mask_s;
    logic [CH_W-1:0] quant_s;
`ifdef COLQ_ROUND_EN
    logic [CH_W:0]   half_s;
    logic [CH_W:0]   sum_s;
`endif

    // Build the keep-mask, optionally round, then apply the mask when enabled.
    always_comb begin
        // A shift at or beyond CH_W shifts every one out, giving an all-zero mask.
        mask_s = {CH_W{1'b1}} << shift_i;
`ifdef COLQ_ROUND_EN
        if (shift_i != 3'd0) begin
            half_s = {{CH_W{1'b0}}, 1'b1} << (shift_i - 3'd1);
        end else begin
            half_s = '0;
        end
        sum_s = {1'b0, ch_i} + half_s;
        if (sum_s[CH_W]) begin
            quant_s = mask_s;
        end else begin
            quant_s = sum_s[CH_W-1:0] & mask_s;
        end
`else
        quant_s = ch_i & mask_s;
`endif
        if (en_i) begin
            q_o = quant_s;
        end else begin
            q_o = ch_i;
        end
    end

endmodule

// File: rtl/col_quant_pipe.sv
// N-pixel RGB quantiser with delay-matched address/valid and frame-aligned
// config updates. Optional round-to-nearest under macro COLQ_ROUND_EN.
module col_quant_pipe
    import col_pkg::*;
#(
    parameter int PIX_PER_WORD = 2,
    parameter int CH_W         = 6,
    parameter int ADDR_W       = 19,
    parameter int DELAY        = 40,
    parameter int DW           = PIX_PER_WORD * 3 * CH_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_pixs,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [2:0]        switch_vals,
    input  logic [1:0]        switch_sels,
    input  logic              change,
    output logic [DW-1:0]     out_pixs,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    output logic              cfg_pending
);

    cfg_state_t        state_q, state_d;
    cfg_t              active_q, active_d;
    cfg_t              pending_q, pending_d;
    logic              change_q;
    logic              cfg_pending_q;

    cfg_t              sw_cfg_s;
    cfg_t              cfg_use_s;
    logic              change_edge_s;
    logic [2:0]        chan_en_s;
    logic [DW-1:0]     quant_d;

    logic [DW-1:0]     data_q  [0:DELAY];
    logic [ADDR_W-1:0] addr_q  [0:DELAY];
    logic              valid_q [0:DELAY];

    assign sw_cfg_s      = cfg_t'{shift: switch_vals, sels: switch_sels};
    assign change_edge_s = change & ~change_q;

    // A pending config takes effect on the very pixel that carries frame_start.
    always_comb begin
        if ((state_q == ST_PENDING) && frame_start) begin
            cfg_use_s = pending_q;
        end else begin
            cfg_use_s = active_q;
        end
    end

    // Decode the channel selection; bit 0 = R, bit 1 = G, bit 2 = B.
    always_comb begin
        chan_en_s = 3'b000;
        case (cfg_use_s.sels)
            SEL_R:   chan_en_s = 3'b001;
            SEL_G:   chan_en_s = 3'b010;
            SEL_B:   chan_en_s = 3'b100;
            SEL_ALL: chan_en_s = 3'b111;
            default: chan_en_s = 3'b000;
        endcase
    end

    for (genvar p = 0; p < PIX_PER_WORD; p++) begin : g_pix
        for (genvar c = 0; c < 3; c++) begin : g_ch
            // Pixel 0 sits in the MSBs; within a pixel the order is R, G, B.
            localparam int LSB = (PIX_PER_WORD - 1 - p) * 3 * CH_W + (2 - c) * CH_W;
            col_quant_chan #(.CH_W(CH_W)) u_chan (
                .ch_i    (in_pixs[LSB +: CH_W]),
                .shift_i (cfg_use_s.shift),
                .en_i    (chan_en_s[c]),
                .q_o     (quant_d[LSB +: CH_W])
            );
        end
    end

    // Config FSM next-state: capture on change edge, apply on frame boundary.
    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        pending_d = pending_q;
        case (state_q)
            ST_ACTIVE: begin
                if (change_edge_s) begin
                    pending_d = sw_cfg_s;
                    state_d   = ST_PENDING;
                end else begin
                    state_d   = ST_ACTIVE;
                end
            end
            ST_PENDING: begin
                if (frame_start) begin
                    active_d = pending_q;
                    state_d  = change_edge_s ? ST_PENDING : ST_ACTIVE;
                end else begin
                    state_d  = ST_PENDING;
                end
                if (change_edge_s) begin
                    pending_d = sw_cfg_s;
                end else begin
                    pending_d = pending_q;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase
    end

    // Config FSM state, active/pending configs and the change edge register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_ACTIVE;
            active_q      <= CFG_PASS;
            pending_q     <= CFG_PASS;
            change_q      <= 1'b0;
            cfg_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            change_q      <= change;
            cfg_pending_q <= (state_d == ST_PENDING);
        end
    end

    // Stage 0 registers the quantised word; stages 1..DELAY are a pure shift.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s <= DELAY; s++) begin
                data_q[s]  <= '0;
                addr_q[s]  <= '0;
                valid_q[s] <= 1'b0;
            end
        end else begin
            data_q[0]  <= quant_d;
            addr_q[0]  <= in_addr;
            valid_q[0] <= in_valid;
            for (int s = 1; s <= DELAY; s++) begin
                data_q[s]  <= data_q[s-1];
                addr_q[s]  <= addr_q[s-1];
                valid_q[s] <= valid_q[s-1];
            end
        end
    end

    assign out_pixs    = data_q[DELAY];
    assign out_addr    = addr_q[DELAY];
    assign out_valid   = valid_q[DELAY];
    assign cfg_pending = cfg_pending_q;

endmodule

// File: tb/tb_col_quant_pipe.sv
// Scoreboard bench for col_quant_pipe: stimulus pushes expected words, a
// negedge monitor pops and checks data, address and latency.
module tb_col_quant_pipe;

    localparam int PPW    = 2;
    localparam int CH_W   = 6;
    localparam int ADDR_W = 19;
    localparam int DELAY  = 40;
    localparam int DW     = PPW * 3 * CH_W;

    localparam logic [DW-1:0]     IDLE_PIX  = 36'hA5A5A5A5A;
    localparam logic [ADDR_W-1:0] IDLE_ADDR = 19'h01234;

`ifdef COLQ_ROUND_EN
    localparam logic [5:0] E_S3 = 6'h30;
    localparam logic [5:0] E_S1 = 6'h30;
    localparam logic [5:0] E_S4 = 6'h30;
`else
    localparam logic [5:0] E_S3 = 6'h28;
    localparam logic [5:0] E_S1 = 6'h2E;
    localparam logic [5:0] E_S4 = 6'h20;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              frame_start = 1'b0;
    logic              in_valid = 1'b0;
    logic [DW-1:0]     in_pixs = '0;
    logic [ADDR_W-1:0] in_addr = '0;
    logic [2:0]        switch_vals = 3'd0;
    logic [1:0]        switch_sels = 2'b11;
    logic              change = 1'b0;
    logic [DW-1:0]     out_pixs;
    logic [ADDR_W-1:0] out_addr;
    logic              out_valid;
    logic              cfg_pending;

    typedef struct {
        logic [DW-1:0]     pix;
        logic [ADDR_W-1:0] addr;
        int                due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    col_quant_pipe #(
        .PIX_PER_WORD(PPW), .CH_W(CH_W), .ADDR_W(ADDR_W), .DELAY(DELAY)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .in_valid(in_valid),
        .in_pixs(in_pixs), .in_addr(in_addr), .switch_vals(switch_vals),
        .switch_sels(switch_sels), .change(change), .out_pixs(out_pixs),
        .out_addr(out_addr), .out_valid(out_valid), .cfg_pending(cfg_pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] word(input logic [5:0] r, input logic [5:0] g,
                                           input logic [5:0] b);
        return {r, g, b, r, g, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One input cycle: drive after the edge, captured at the next edge.
    task automatic step(input logic fs, input logic chg, input logic v,
                        input logic [DW-1:0] pix, input logic [ADDR_W-1:0] addr,
                        input logic [DW-1:0] exp);
        @(posedge clk);
        #1;
        frame_start = fs;
        change      = chg;
        in_valid    = v;
        in_pixs     = pix;
        in_addr     = addr;
        if (v) sb_q.push_back('{pix: exp, addr: addr, due: cyc + DELAY + 1});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, IDLE_PIX, IDLE_ADDR, '0);
    endtask

    // Monitor: every valid output must match the oldest expected word.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_valid: got out_valid=1 addr=%0h expected no output",
                         out_addr);
            end else begin
                mon_e = sb_q.pop_front();
                chk("out_pixs", 64'(out_pixs), 64'(mon_e.pix));
                chk("out_addr", 64'(out_addr), 64'(mon_e.addr));
                chk("latency", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_pixs", 64'(out_pixs), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_cfg_pending", 64'(cfg_pending), 64'd0);
        reset = 1'b1;

        // Default config is passthrough.
        step(1'b0, 1'b0, 1'b1, 36'hFFFFFFFFF, 19'd5, 36'hFFFFFFFFF);
        idle();

        // Mid-frame change (G only, shift 2) waits for frame_start.
        switch_vals = 3'd2; switch_sels = 2'b01;
        step(1'b0, 1'b1, 1'b1, word(6'h3F, 6'h3F, 6'h3F), 19'd6, word(6'h3F, 6'h3F, 6'h3F));
        idle();
        chk("pending_after_change", 64'(cfg_pending), 64'd1);
        switch_vals = 3'd7; switch_sels = 2'b00;
        step(1'b0, 1'b0, 1'b1, word(6'h3F, 6'h3F, 6'h3F), 19'd7, word(6'h3F, 6'h3F, 6'h3F));
        step(1'b1, 1'b0, 1'b1, word(6'h3F, 6'h3F, 6'h3F), 19'd8, word(6'h3F, 6'h3C, 6'h3F));
        idle();
        chk("pending_cleared_g", 64'(cfg_pending), 64'd0);

        // Shift 3 on all channels, including the saturating pattern.
        switch_vals = 3'd3; switch_sels = 2'b11;
        step(1'b0, 1'b1, 1'b0, IDLE_PIX, IDLE_ADDR, '0);
        idle();
        step(1'b1, 1'b0, 1'b1, word(6'h2F, 6'h2F, 6'h2F), 19'd9, word(E_S3, E_S3, E_S3));
        step(1'b0, 1'b0, 1'b1, word(6'h3F, 6'h3F, 6'h3F), 19'd10, word(6'h38, 6'h38, 6'h38));
        idle();

        // Shift beyond channel width on R only clears R.
        switch_vals = 3'd7; switch_sels = 2'b00;
        step(1'b0, 1'b1, 1'b0, IDLE_PIX, IDLE_ADDR, '0);
        idle();
        step(1'b1, 1'b0, 1'b1, word(6'h3F, 6'h3F, 6'h3F), 19'd11, word(6'h00, 6'h3F, 6'h3F));
        idle();

        // PENDING with simultaneous frame_start and change edge.
        switch_vals = 3'd1; switch_sels = 2'b11;
        step(1'b0, 1'b1, 1'b0, IDLE_PIX, IDLE_ADDR, '0);
        idle();
        chk("pending_v1", 64'(cfg_pending), 64'd1);
        switch_vals = 3'd4;
        step(1'b1, 1'b1, 1'b1, word(6'h2F, 6'h2F, 6'h2F), 19'd12, word(E_S1, E_S1, E_S1));
        idle();
        chk("pending_stays", 64'(cfg_pending), 64'd1);
        step(1'b1, 1'b0, 1'b1, word(6'h2F, 6'h2F, 6'h2F), 19'd13, word(E_S4, E_S4, E_S4));
        idle();
        chk("pending_cleared_v4", 64'(cfg_pending), 64'd0);

        // Change edge while ACTIVE on a frame_start is only captured.
        switch_vals = 3'd0;
        step(1'b1, 1'b1, 1'b1, word(6'h2F, 6'h2F, 6'h2F), 19'd14, word(E_S4, E_S4, E_S4));
        idle();
        chk("pending_active_fs", 64'(cfg_pending), 64'd1);
        step(1'b1, 1'b0, 1'b1, word(6'h2F, 6'h2F, 6'h2F), 19'd15, word(6'h2F, 6'h2F, 6'h2F));
        idle();
        chk("pending_cleared_pass", 64'(cfg_pending), 64'd0);

        repeat (DELAY + 2) idle();
        chk("drained", 64'(sb_q.size()), 64'd0);

        // Reset with words in flight and a config pending.
        switch_vals = 3'd5;
        step(1'b0, 1'b1, 1'b1, word(6'h2F, 6'h2F, 6'h2F), 19'd20, '0);
        step(1'b0, 1'b0, 1'b1, word(6'h2F, 6'h2F, 6'h2F), 19'd21, '0);
        step(1'b0, 1'b0, 1'b1, word(6'h2F, 6'h2F, 6'h2F), 19'd22, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        chk("mid_rst_out_pixs", 64'(out_pixs), 64'd0);
        chk("mid_rst_out_addr", 64'(out_addr), 64'd0);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_cfg_pending", 64'(cfg_pending), 64'd0);
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b1, word(6'h2F, 6'h2F, 6'h2F), 19'd30, word(6'h2F, 6'h2F, 6'h2F));
        repeat (DELAY + 4) idle();
        chk("final_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
